four_phase_monitor: RTL

// - Receive-side checker for the four-phase clock bus (Phi1..Phi4), placed wherever phases are consumed.
// - Decodes the one-hot phase vector back to a 2-bit phase index.
// - Verifies the legal rotation Phi1->Phi2->Phi3->Phi4->Phi1 and declares lock.
// - Counts completed rotations and raises a sticky fault with a cause code when the sequence breaks after lock.

---
 rtl/four_phase_monitor_pkg.sv | 25 ++
 rtl/four_phase_monitor_if.sv | 30 +++
 rtl/four_phase_monitor_decode.sv | 21 ++
 rtl/four_phase_monitor.sv | 138 +++++++++++++
 4 files changed

// File: rtl/four_phase_monitor_pkg.sv
// Shared encodings for the four-phase clock bus generator and monitor.
// State and fault-cause constants live here so both sides agree.
package four_phase_monitor_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_ONEHOT = 2'b01,
    ERR_SKIP   = 2'b10,
    ERR_STALL  = 2'b11
  } err_e;

  function automatic logic [1:0] next_idx(
    input logic [1:0] i
  );
    return i + 2'd1;
  endfunction

endpackage

// File: rtl/four_phase_monitor_if.sv
// Phase bus plus monitor status, as seen by a receive-side checker.
// master drives the phases; slave is the monitor.
interface four_phase_monitor_if #(
  parameter int CNT_W = 16
);
  logic             Phi1;
  logic             Phi2;
  logic             Phi3;
  logic             Phi4;
  logic             ClearErr;
  logic [1:0]       PhaseIdx;
  logic             PhaseValid;
  logic             StartOfCycle;
  logic             Locked;
  logic             Error;
  logic [1:0]       ErrCode;
  logic [CNT_W-1:0] RotCount;

  modport master (
    output Phi1, Phi2, Phi3, Phi4, ClearErr,
    input  PhaseIdx, PhaseValid, StartOfCycle,
    input  Locked, Error, ErrCode, RotCount
  );

  modport slave (
    input  Phi1, Phi2, Phi3, Phi4, ClearErr,
    output PhaseIdx, PhaseValid, StartOfCycle,
    output Locked, Error, ErrCode, RotCount
  );
endinterface

// File: rtl/four_phase_monitor_decode.sv
// Combinational one-hot phase vector to 2-bit index decoder.
// idx is 0 whenever the vector is not one-hot.
module four_phase_monitor_decode (
  input  logic [3:0] ph,
  output logic [1:0] idx,
  output logic       onehot
);

  always_comb begin
    idx    = 2'd0;
    onehot = 1'b1;
    case (ph)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

endmodule

// File: rtl/four_phase_monitor.sv
// Four-phase bus rotation checker: decode, lock, count rotations,
// and latch a sticky fault cause when the sequence breaks after lock.
module four_phase_monitor
  import four_phase_monitor_pkg::*;
#(
  parameter int LOCK_COUNT = 2,
  parameter int CNT_W      = 16
) (
  input logic                inClock,
  input logic                Reset,
  four_phase_monitor_if.slave bus
);

  localparam int GW = $clog2(LOCK_COUNT + 1) < 1 ?
                      1 : $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] GOAL = GW'(LOCK_COUNT);

  mon_state_e       state_q, state_n;
  logic [GW-1:0]    gc_q, gc_n;
  logic [1:0]       prev_q, prev_n;
  logic [CNT_W-1:0] rot_q, rot_n;
  logic [1:0]       idx_q;
  logic             valid_q;
  logic             sof_q, sof_n;
  logic             lock_q;
  logic             err_q, err_n;
  err_e             code_q, code_n;

  logic [3:0] ph;
  logic [1:0] idx;
  logic       onehot;
  logic       match;
  logic       wrap;

  assign ph = {bus.Phi4, bus.Phi3, bus.Phi2, bus.Phi1};

  four_phase_monitor_decode u_dec (
    .ph     (ph),
    .idx    (idx),
    .onehot (onehot)
  );

  assign match = onehot && (idx == next_idx(prev_q));
  assign wrap  = match && (idx == 2'd0);

  always_comb begin
    state_n = state_q;
    gc_n    = gc_q;
    prev_n  = prev_q;
    rot_n   = rot_q;
    sof_n   = 1'b0;
    err_n   = err_q;
    code_n  = code_q;
    unique case (state_q)
      SEARCH: begin
        if (onehot && idx == 2'd0) begin
          state_n = ACQUIRE;
          gc_n    = '0;
          prev_n  = 2'd0;
        end
      end
      ACQUIRE: begin
        if (match) begin
          prev_n = idx;
          if (wrap) begin
            gc_n = gc_q + 1'b1;
            if (gc_q + 1'b1 == GOAL)
              state_n = LOCKED;
          end
        end else begin
          state_n = SEARCH;
        end
      end
      LOCKED: begin
        if (match) begin
          prev_n = idx;
          if (wrap) begin
            rot_n = rot_q + 1'b1;
            sof_n = 1'b1;
          end
        end else begin
          state_n = FAULT;
          err_n   = 1'b1;
          if (!onehot)
            code_n = ERR_ONEHOT;
          else if (idx == prev_q)
            code_n = ERR_STALL;
          else
            code_n = ERR_SKIP;
        end
      end
      FAULT: begin
        if (bus.ClearErr) begin
          state_n = SEARCH;
          err_n   = 1'b0;
          code_n  = ERR_NONE;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge inClock) begin
    if (Reset) begin
      state_q <= SEARCH;
      gc_q    <= '0;
      prev_q  <= 2'd0;
      rot_q   <= '0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_n;
      gc_q    <= gc_n;
      prev_q  <= prev_n;
      rot_q   <= rot_n;
      valid_q <= onehot;
      if (onehot)
        idx_q <= idx;
      sof_q   <= sof_n;
      lock_q  <= (state_n == LOCKED);
      err_q   <= err_n;
      code_q  <= code_n;
    end
  end

  assign bus.PhaseIdx     = idx_q;
  assign bus.PhaseValid   = valid_q;
  assign bus.StartOfCycle = sof_q;
  assign bus.Locked       = lock_q;
  assign bus.Error        = err_q;
  assign bus.ErrCode      = code_q;
  assign bus.RotCount     = rot_q;

endmodule
